// File: rtl/fifo_drain_if.sv
// fifo_drain_if: groups the command/status, FIFO read-side and output stream signals of
// fifo_drain.
//   master: the drain controller (drives busy/done/xfer_count, rn, out_data/out_valid)
//   slave : the environment (drives start/len, empty/fifo_data, out_ready)
interface fifo_drain_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LEN_W = 16
);
  // Command / status
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] xfer_count;
  // FIFO read side
  logic             rn;
  logic             empty;
  logic [WIDTH-1:0] fifo_data;
  // Output stream
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    input  start, len, empty, fifo_data, out_ready,
    output busy, done, xfer_count, rn, out_data, out_valid
  );

  modport slave (
    output start, len, empty, fifo_data, out_ready,
    input  busy, done, xfer_count, rn, out_data, out_valid
  );
endinterface

// File: rtl/fifo_drain.sv
// fifo_drain: read-side controller for a synchronous FIFO with one-cycle registered read
// latency. On start it pops exactly len words, hides the read latency behind a 2-entry
// skid buffer and presents the words on a valid/ready stream, then pulses done.
// Ports:
//   clock_i  : rising-edge clock
//   reset_ni : asynchronous active-low reset
//   bus      : fifo_drain_if master (start/len/busy/done/xfer_count, rn/empty/fifo_data,
//              out_data/out_valid/out_ready)
module fifo_drain #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LEN_W = 16
) (
  input logic          clock_i,
  input logic          reset_ni,
  fifo_drain_if.master bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] issued_q, issued_d;
  logic [LEN_W-1:0] xfer_q, xfer_d;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] buf_q [2];
  logic [WIDTH-1:0] buf_d [2];
  logic             head_q, head_d;
  logic [1:0]       cnt_q, cnt_d;

  logic       out_valid;
  logic       pop;
  logic       push;
  logic       rn;
  logic       tail;
  logic [2:0] occ;

  assign out_valid = (cnt_q != 2'd0);
  assign pop       = out_valid && bus.out_ready;
  // The word requested last cycle is on fifo_data now and lands in the buffer this edge.
  assign push      = inflight_q;
  // Occupancy after this edge if nothing new were requested: buffered + in flight - leaving.
  assign occ       = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rn        = (state_q == StRun) && !bus.empty && (issued_q < len_q) && (occ < 3'd2);
  // Tail slot: head when empty, the other slot when one entry is held.
  assign tail      = head_q ^ cnt_q[0];

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    xfer_d     = xfer_q;
    buf_d      = buf_q;
    head_d     = head_q;
    cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
    inflight_d = rn;

    if (rn) begin
      issued_d = issued_q + LEN_W'(1);
    end
    if (push) begin
      buf_d[tail] = bus.fifo_data;
    end
    if (pop) begin
      head_d = ~head_q;
      xfer_d = xfer_q + LEN_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          len_d      = bus.len;
          issued_d   = '0;
          xfer_d     = '0;
          cnt_d      = 2'd0;
          head_d     = 1'b0;
          inflight_d = 1'b0;
          state_d    = (bus.len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        // len_q >= 1 here, so len_q - 1 cannot wrap.
        if (pop && (xfer_q == len_q - LEN_W'(1))) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= StIdle;
      len_q      <= '0;
      issued_q   <= '0;
      xfer_q     <= '0;
      inflight_q <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      head_q     <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      xfer_q     <= xfer_d;
      inflight_q <= inflight_d;
      buf_q      <= buf_d;
      head_q     <= head_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.rn         = rn;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = buf_q[head_q];
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = (state_q == StDone);
  assign bus.xfer_count = xfer_q;

endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: directed self-checking bench for fifo_drain with a behavioural FIFO
// (registered read data, registered empty flag) and a negedge stream monitor.
module tb_fifo_drain;

  logic clock;
  logic reset_n;

  fifo_drain_if #(.WIDTH(32), .LEN_W(16)) bus ();

  fifo_drain #(.WIDTH(32), .LEN_W(16)) dut (
    .clock_i  (clock),
    .reset_ni (reset_n),
    .bus      (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural FIFO: one-cycle registered read, writes visible after the write edge.
  logic        wr_en;
  logic [31:0] wr_data;
  logic        fifo_clr;
  logic [31:0] mem[$];
  int          fifo_level = 0;

  always @(posedge clock) begin
    if (fifo_clr) begin
      mem.delete();
    end else begin
      if (bus.rn && mem.size() != 0) bus.fifo_data <= mem.pop_front();
      if (wr_en) mem.push_back(wr_data);
    end
    bus.empty  <= (mem.size() == 0);
    fifo_level <= mem.size();
  end

  // Stream / FIFO-side monitor, sampled mid-cycle.
  int          rn_cnt = 0, done_cnt = 0, acc_cnt = 0, busy_cnt = 0;
  int          overread_err = 0, occ_err = 0, stall_err = 0;
  int          occ = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic [31:0] rx[$];
  logic        mon_hs;
  assign mon_hs = bus.out_valid && bus.out_ready;

  always @(negedge clock) begin
    if (!reset_n) begin
      occ        <= 0;
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && !(bus.out_valid && bus.out_data == prev_data)) stall_err <= stall_err + 1;
      if (bus.rn) rn_cnt <= rn_cnt + 1;
      if (bus.rn && bus.empty) overread_err <= overread_err + 1;
      if (bus.rn && (occ - (mon_hs ? 1 : 0) + 1 > 2)) occ_err <= occ_err + 1;
      if (mon_hs) begin
        rx.push_back(bus.out_data);
        acc_cnt <= acc_cnt + 1;
      end
      if (bus.done) done_cnt <= done_cnt + 1;
      if (bus.busy) busy_cnt <= busy_cnt + 1;
      occ        <= occ + (bus.rn ? 1 : 0) - (mon_hs ? 1 : 0);
      prev_stall <= bus.out_valid && !bus.out_ready;
      prev_data  <= bus.out_data;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fifo_write(input logic [31:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic fifo_flush();
    fifo_clr = 1'b1;
    tick();
    fifo_clr = 1'b0;
    tick();
  endtask

  task automatic kick(input logic [15:0] l);
    bus.len   = l;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic run_until_done(input int d0, input int max, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max; c++) begin
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (done_cnt != d0) ok = 1'b1;
  endtask

  task automatic test_reset();
    vectors++;
    if (bus.busy !== 1'b0) begin
      $display("FAIL reset_busy: got %b want 0", bus.busy); miscompares++;
    end
    vectors++;
    if (bus.done !== 1'b0) begin
      $display("FAIL reset_done: got %b want 0", bus.done); miscompares++;
    end
    vectors++;
    if (bus.rn !== 1'b0) begin
      $display("FAIL reset_rn: got %b want 0", bus.rn); miscompares++;
    end
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL reset_valid: got %b want 0", bus.out_valid); miscompares++;
    end
    vectors++;
    if (bus.out_data !== 32'd0 || bus.xfer_count !== 16'd0) begin
      $display("FAIL reset_data_count: got %0h/%0d want 0/0", bus.out_data, bus.xfer_count);
      miscompares++;
    end
  endtask

  task automatic test_basic();
    int r0, d0, b0;
    fifo_write(32'd100);
    fifo_write(32'd150);
    bus.out_ready = 1'b1;
    r0 = rn_cnt; d0 = done_cnt; b0 = rx.size();
    kick(16'd2);                       // now just after edge 0
    vectors++;
    if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
      $display("FAIL basic_e0: got busy=%b valid=%b want 1/0", bus.busy, bus.out_valid);
      miscompares++;
    end
    tick();                            // edge 1
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL basic_e1_valid: got %b want 0", bus.out_valid); miscompares++;
    end
    tick();                            // edge 2: first word captured
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd100) begin
      $display("FAIL basic_first: got v=%b d=%0d want 1/100", bus.out_valid, bus.out_data);
      miscompares++;
    end
    tick();                            // edge 3
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd150) begin
      $display("FAIL basic_second: got v=%b d=%0d want 1/150", bus.out_valid, bus.out_data);
      miscompares++;
    end
    tick();                            // edge 4: last word accepted
    vectors++;
    if (bus.done !== 1'b1 || bus.xfer_count !== 16'd2) begin
      $display("FAIL basic_done: got done=%b cnt=%0d want 1/2", bus.done, bus.xfer_count);
      miscompares++;
    end
    tick();
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      $display("FAIL basic_idle: got done=%b busy=%b want 0/0", bus.done, bus.busy);
      miscompares++;
    end
    vectors++;
    if (rn_cnt - r0 != 2 || done_cnt - d0 != 1) begin
      $display("FAIL basic_counts: got rn=%0d done=%0d want 2/1", rn_cnt - r0, done_cnt - d0);
      miscompares++;
    end
    vectors++;
    if (rx.size() - b0 != 2 || rx[b0] !== 32'd100 || rx[b0+1] !== 32'd150) begin
      $display("FAIL basic_stream: got %0d words want 100,150", rx.size() - b0);
      miscompares++;
    end
    vectors++;
    if (bus.empty !== 1'b1) begin
      $display("FAIL basic_empty: got %b want 1", bus.empty); miscompares++;
    end
  endtask

  task automatic test_backpressure();
    int d0, b0, a0, s0, o0, v0;
    bit ok;
    for (int i = 1; i <= 5; i++) fifo_write(32'(i));
    d0 = done_cnt; b0 = rx.size(); a0 = acc_cnt; s0 = stall_err; o0 = occ_err; v0 = overread_err;
    bus.out_ready = 1'b1;
    kick(16'd5);
    ok = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
      bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
      tick();
    end
    bus.out_ready = 1'b1;
    vectors++;
    if (!ok) begin
      $display("FAIL bp_timeout: got no done want done"); miscompares++;
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (rx.size() <= b0 + i || rx[b0+i] !== 32'(i + 1)) begin
        $display("FAIL bp_word%0d: got %0d want %0d", i,
                 (rx.size() > b0 + i) ? rx[b0+i] : 32'hffff_ffff, i + 1);
        miscompares++;
      end
    end
    vectors++;
    if (acc_cnt - a0 != 5 || bus.xfer_count !== 16'd5) begin
      $display("FAIL bp_count: got acc=%0d cnt=%0d want 5/5", acc_cnt - a0, bus.xfer_count);
      miscompares++;
    end
    vectors++;
    if (stall_err != s0) begin
      $display("FAIL bp_stable: got %0d unstable cycles want 0", stall_err - s0); miscompares++;
    end
    vectors++;
    if (occ_err != o0 || overread_err != v0) begin
      $display("FAIL bp_rn_guard: got occ=%0d over=%0d want 0/0", occ_err - o0,
               overread_err - v0);
      miscompares++;
    end
  endtask

  task automatic test_empty_stall();
    int d0, b0, r0, v0;
    bit ok;
    d0 = done_cnt; b0 = rx.size(); r0 = rn_cnt; v0 = overread_err;
    bus.out_ready = 1'b1;
    kick(16'd3);
    repeat (4) tick();
    vectors++;
    if (bus.rn !== 1'b0 || bus.busy !== 1'b1) begin
      $display("FAIL stall_idle_rn: got rn=%b busy=%b want 0/1", bus.rn, bus.busy);
      miscompares++;
    end
    fifo_write(32'd7);
    repeat (5) tick();
    fifo_write(32'd8);
    repeat (5) tick();
    fifo_write(32'd9);
    run_until_done(d0, 40, ok);
    vectors++;
    if (!ok) begin
      $display("FAIL stall_timeout: got no done want done"); miscompares++;
    end
    vectors++;
    if (rx.size() - b0 != 3 || rx[b0] !== 32'd7 || rx[b0+1] !== 32'd8 || rx[b0+2] !== 32'd9) begin
      $display("FAIL stall_stream: got %0d words want 7,8,9", rx.size() - b0); miscompares++;
    end
    vectors++;
    if (overread_err != v0 || rn_cnt - r0 != 3) begin
      $display("FAIL stall_rn: got over=%0d rn=%0d want 0/3", overread_err - v0, rn_cnt - r0);
      miscompares++;
    end
  endtask

  task automatic test_zero_and_busy_start();
    int d0, r0, bz0, b0;
    bit ok;
    d0 = done_cnt; r0 = rn_cnt; bz0 = busy_cnt;
    kick(16'd0);
    vectors++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin
      $display("FAIL zero_done: got done=%b busy=%b want 1/1", bus.done, bus.busy);
      miscompares++;
    end
    tick();
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || rn_cnt != r0 || busy_cnt - bz0 != 1) begin
      $display("FAIL zero_after: got done=%b busy=%b rn=%0d busyc=%0d want 0/0/0/1",
               bus.done, bus.busy, rn_cnt - r0, busy_cnt - bz0);
      miscompares++;
    end
    fifo_write(32'd11);
    fifo_write(32'd12);
    fifo_write(32'd13);
    d0 = done_cnt; r0 = rn_cnt; b0 = rx.size();
    bus.out_ready = 1'b1;
    kick(16'd2);
    bus.len   = 16'd7;
    bus.start = 1'b1;
    repeat (2) tick();
    bus.start = 1'b0;
    bus.len   = 16'd0;
    run_until_done(d0, 40, ok);
    vectors++;
    if (!ok || rn_cnt - r0 != 2 || bus.xfer_count !== 16'd2 || fifo_level != 1) begin
      $display("FAIL busy_start: got ok=%0d rn=%0d cnt=%0d left=%0d want 1/2/2/1",
               ok, rn_cnt - r0, bus.xfer_count, fifo_level);
      miscompares++;
    end
    vectors++;
    if (rx.size() - b0 != 2 || rx[b0] !== 32'd11 || rx[b0+1] !== 32'd12) begin
      $display("FAIL busy_stream: got %0d words want 11,12", rx.size() - b0); miscompares++;
    end
    fifo_flush();
  endtask

  task automatic test_exact_count();
    int d0, r0, b0;
    bit ok;
    for (int i = 21; i <= 26; i++) fifo_write(32'(i));
    d0 = done_cnt; r0 = rn_cnt; b0 = rx.size();
    bus.out_ready = 1'b1;
    kick(16'd4);
    run_until_done(d0, 40, ok);
    vectors++;
    if (!ok || rn_cnt - r0 != 4 || fifo_level != 2 || bus.xfer_count !== 16'd4) begin
      $display("FAIL exact: got ok=%0d rn=%0d left=%0d cnt=%0d want 1/4/2/4",
               ok, rn_cnt - r0, fifo_level, bus.xfer_count);
      miscompares++;
    end
    vectors++;
    if (rx.size() - b0 != 4 || rx[b0] !== 32'd21 || rx[b0+3] !== 32'd24) begin
      $display("FAIL exact_stream: got %0d words want 21..24", rx.size() - b0); miscompares++;
    end
    fifo_flush();
  endtask

  task automatic test_reset_mid_transfer();
    int d0, a0, b0;
    bit ok;
    for (int i = 31; i <= 36; i++) fifo_write(32'(i));
    d0 = done_cnt; a0 = acc_cnt;
    bus.out_ready = 1'b1;
    kick(16'd4);
    for (int c = 0; c < 20 && acc_cnt - a0 < 2; c++) tick();
    vectors++;
    if (acc_cnt - a0 != 2) begin
      $display("FAIL rst_mid_wait: got %0d accepted want 2", acc_cnt - a0); miscompares++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.rn !== 1'b0 ||
        bus.out_data !== 32'd0 || bus.xfer_count !== 16'd0 || bus.done !== 1'b0) begin
      $display("FAIL rst_mid_outputs: got busy=%b v=%b rn=%b d=%0d cnt=%0d done=%b want all 0",
               bus.busy, bus.out_valid, bus.rn, bus.out_data, bus.xfer_count, bus.done);
      miscompares++;
    end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    vectors++;
    if (done_cnt != d0 || fifo_level != 2) begin
      $display("FAIL rst_mid_nodone: got done=%0d left=%0d want 0/2", done_cnt - d0, fifo_level);
      miscompares++;
    end
    b0 = rx.size();
    kick(16'd1);
    run_until_done(d0, 40, ok);
    vectors++;
    if (!ok || rx.size() - b0 != 1 || rx[b0] !== 32'd35 || fifo_level != 1) begin
      $display("FAIL rst_restart: got ok=%0d words=%0d left=%0d want 1/1(35)/1",
               ok, rx.size() - b0, fifo_level);
      miscompares++;
    end
    fifo_flush();
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.out_ready = 1'b0;
    wr_en         = 1'b0;
    wr_data       = '0;
    fifo_clr      = 1'b0;
    repeat (3) tick();
    test_reset();
    reset_n = 1'b1;
    tick();
    test_basic();
    test_backpressure();
    test_empty_stall();
    test_zero_and_busy_start();
    test_exact_count();
    test_reset_mid_transfer();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
